clk_rate_monitor: RTL and testbench
===================================

Name: clk_rate_monitor

Overview:
- Consumes the 24-bit rate word from the clock rate counter on clk125 and qualifies it against an expected window.
- Debounces the qualification into a lock state machine and raises clk_ok for the monitored clock.
- Counts loss-of-lock events for slow-control readback.
- Directly downstream of the rate counter, same clk125 domain; no CDC needed on rate_value.

Parameters:
- SAMPLE_PERIOD, 8388609: clk125 cycles between samples; equals the rate counter update period (2^23+1).
- EXP_COUNT, 400000: expected rate word (f_test/100 for a 10 ms gate); 400000 = 40 MHz.
- TOL, 400: allowed absolute deviation from EXP_COUNT; bounds are inclusive.
- LOCK_CNT, 3: consecutive in-range samples needed to lock; range 1..15.
- LOSS_CNT, 2: consecutive out-of-range samples needed to drop lock; range 1..15.

Ports:
- clk125  in  1  system clock, 125 MHz.
- reset_n_in  in  1  asynchronous active-low reset.
- rate_value  in  24  rate word from the upstream counter; 24'hFFFFFF means upstream is in reset.
- clear_counts  in  1  synchronous pulse; zeroes glitch_count.
- sample_strobe  out  1  one-cycle pulse; the other outputs were updated on this cycle.
- rate_latched  out  24  last sampled rate_value.
- in_range  out  1  last sample was within [lo,hi].
- clk_state  out  2  0=IDLE, 1=ACQ, 2=LOCKED, 3=FAULT.
- clk_ok  out  1  high when clk_state==LOCKED.
- glitch_count  out  16  LOCKED->FAULT transitions; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): tick counter 0, state IDLE, good_cnt/bad_cnt 0; all outputs 0.
- Sample timer:
  - 24-bit counter counts 0..SAMPLE_PERIOD-1, then wraps to 0.
  - A tick occurs on the cycle counter==SAMPLE_PERIOD-1.
  - First tick occurs at the SAMPLE_PERIOD-th rising edge after reset release.
  - No phase alignment to the upstream update is needed: rate_value is register-held for a full period in the same domain.
- On a tick, all evaluation registers update at that edge.
  - sample_strobe is high for exactly the one following cycle.
  - rate_latched, in_range, clk_state, clk_ok and glitch_count are valid on that strobe cycle (1-cycle latency from the tick).
- Window bounds, computed combinationally from the parameters:
  - lo = EXP_COUNT-TOL, saturating at 0.
  - hi = EXP_COUNT+TOL, saturating at 24'hFFFFFE.
  - in range = lo <= rate_value <= hi, unsigned compare.
- Invalid sample (rate_value==24'hFFFFFF):
  - state -> IDLE; good_cnt = bad_cnt = 0; in_range = 0; glitch_count unchanged.
  - rate_latched still captures the value.
- In-range sample: good_cnt = min(good_cnt+1, 15); bad_cnt = 0.
  - IDLE -> ACQ; if LOCK_CNT==1, go directly to LOCKED.
  - ACQ -> LOCKED when the updated good_cnt >= LOCK_CNT; otherwise stay in ACQ.
  - LOCKED stays LOCKED.
  - FAULT -> ACQ with good_cnt = 1; goes to LOCKED instead if LOCK_CNT==1.
- Out-of-range sample (including rate_value 0, i.e. a stopped clock): good_cnt = 0; bad_cnt = min(bad_cnt+1, 15).
  - IDLE stays IDLE.
  - ACQ -> IDLE.
  - LOCKED -> FAULT when the updated bad_cnt >= LOSS_CNT, and glitch_count increments (saturating). Otherwise stay LOCKED.
  - FAULT stays FAULT.
- clear_counts:
  - Takes effect on any cycle.
  - If it coincides with an increment, the clear wins and the result is 0.
  - Does not affect state, the debounce counters, or the sample timer.
- clk_ok is registered and equals (clk_state==LOCKED); there is no combinational path from rate_value to any output.
- Reset asserted mid-period: everything returns to reset values immediately; the sample timer restarts from 0.

Test Plan:
All scenarios use SAMPLE_PERIOD=16, EXP_COUNT=400000, TOL=400, LOCK_CNT=3, LOSS_CNT=2.
- rate_value=400000 held from reset:
  - strobes at cycles 17, 33, 49; clk_state goes 1, 1, 2.
  - clk_ok rises on the cycle-49 strobe.
  - rate_latched=400000; glitch_count=0.
- Boundary values 399600 and 400400 -> in_range=1; 399599 and 400401 -> in_range=0.
- Locked, then 0 for two samples:
  - first sample: in_range=0, state stays 2.
  - second sample: state=3, clk_ok=0, glitch_count=1.
  - Return to 400000: state 1, 1, 2 over the next three samples.
- Locked, then a single out-of-range sample (500000) followed by 400000 -> remains LOCKED, glitch_count=0.
- Locked, then rate_value=24'hFFFFFF -> state=0, clk_ok=0, rate_latched=24'hFFFFFF, glitch_count unchanged.
- clear_counts asserted on the same cycle as a LOCKED->FAULT increment -> glitch_count=0.
- reset_n_in pulsed low mid-period -> all outputs 0 immediately; next strobe 17 cycles after release.

Source files
------------

// File: rtl/clk_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rate_monitor
//  Description : Qualifies the 24-bit rate word from the clock rate counter
//                against an [lo,hi] window once per sample period, debounces
//                the result into an IDLE/ACQ/LOCKED/FAULT lock machine,
//                raises clk_ok while locked and counts loss-of-lock events.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk125         in   1   system clock (125 MHz)
//    reset_n_in     in   1   asynchronous active-low reset
//    rate_value     in  24   rate word; 24'hFFFFFF = upstream in reset
//    clear_counts   in   1   synchronous pulse, zeroes glitch_count
//    sample_strobe  out  1   one-cycle pulse, other outputs just updated
//    rate_latched   out 24   last sampled rate_value
//    in_range       out  1   last sample was inside [lo,hi]
//    clk_state      out  2   0=IDLE 1=ACQ 2=LOCKED 3=FAULT
//    clk_ok         out  1   high while clk_state==LOCKED
//    glitch_count   out 16   LOCKED->FAULT transitions, saturating
// ============================================================================
module clk_rate_monitor #(
  parameter int unsigned SAMPLE_PERIOD = 8388609,
  parameter int unsigned EXP_COUNT     = 400000,
  parameter int unsigned TOL           = 400,
  parameter int unsigned LOCK_CNT      = 3,
  parameter int unsigned LOSS_CNT      = 2
) (
  input  logic        clk125,
  input  logic        reset_n_in,
  input  logic [23:0] rate_value,
  input  logic        clear_counts,
  output logic        sample_strobe,
  output logic [23:0] rate_latched,
  output logic        in_range,
  output logic [1:0]  clk_state,
  output logic        clk_ok,
  output logic [15:0] glitch_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [23:0] INVALID_WORD = 24'hFFFFFF;
  localparam logic [23:0] TICK_LAST    = 24'(SAMPLE_PERIOD - 1);

  // Window bounds: lo saturates at 0, hi saturates just below the invalid
  // marker so that 24'hFFFFFF can never qualify as in range.
  localparam int unsigned LO_INT  = (EXP_COUNT > TOL) ? (EXP_COUNT - TOL) : 0;
  localparam int unsigned HI_RAW  = EXP_COUNT + TOL;
  localparam int unsigned HI_INT  = (HI_RAW > 32'h00FF_FFFE) ? 32'h00FF_FFFE : HI_RAW;
  localparam logic [23:0] LO_BOUND = 24'(LO_INT);
  localparam logic [23:0] HI_BOUND = 24'(HI_INT);

  localparam logic [3:0]  LOCK_TH  = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_TH  = 4'(LOSS_CNT);
  localparam logic [3:0]  CNT_MAX  = 4'hF;
  localparam logic [15:0] GLITCH_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [23:0] tick_cnt_q,     tick_cnt_d;
  state_e      state_q,        state_d;
  logic [3:0]  good_q,         good_d;
  logic [3:0]  bad_q,          bad_d;
  logic        strobe_q,       strobe_d;
  logic [23:0] rate_latched_q, rate_latched_d;
  logic        in_range_q,     in_range_d;
  logic        clk_ok_q,       clk_ok_d;
  logic [15:0] glitch_q,       glitch_d;

  // Combinational helpers
  logic        tick;
  logic        sample_valid;
  logic        sample_in;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;
  logic        glitch_inc;

  // --------------------------------------------------------------------------
  // Register process
  // --------------------------------------------------------------------------
  always_ff @(posedge clk125 or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tick_cnt_q     <= '0;
      state_q        <= ST_IDLE;
      good_q         <= '0;
      bad_q          <= '0;
      strobe_q       <= 1'b0;
      rate_latched_q <= '0;
      in_range_q     <= 1'b0;
      clk_ok_q       <= 1'b0;
      glitch_q       <= '0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      state_q        <= state_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
      strobe_q       <= strobe_d;
      rate_latched_q <= rate_latched_d;
      in_range_q     <= in_range_d;
      clk_ok_q       <= clk_ok_d;
      glitch_q       <= glitch_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state process
  // --------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything, no strobe, no glitch event.
    tick_cnt_d     = tick_cnt_q;
    state_d        = state_q;
    good_d         = good_q;
    bad_d          = bad_q;
    strobe_d       = 1'b0;
    rate_latched_d = rate_latched_q;
    in_range_d     = in_range_q;
    glitch_d       = glitch_q;
    glitch_inc     = 1'b0;

    // Sample timer. rate_value is held for a whole period by the upstream
    // counter in this same domain, so any phase of the tick is safe.
    tick = (tick_cnt_q == TICK_LAST);
    if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 24'd1;
    end

    sample_valid = (rate_value != INVALID_WORD);
    sample_in    = sample_valid && (rate_value >= LO_BOUND) && (rate_value <= HI_BOUND);
    good_inc     = (good_q == CNT_MAX) ? CNT_MAX : (good_q + 4'd1);
    bad_inc      = (bad_q  == CNT_MAX) ? CNT_MAX : (bad_q  + 4'd1);

    if (tick) begin
      strobe_d       = 1'b1;
      rate_latched_d = rate_value;
      in_range_d     = sample_in;

      if (!sample_valid) begin
        // Upstream counter is itself in reset: forget all history.
        state_d = ST_IDLE;
        good_d  = '0;
        bad_d   = '0;
      end else if (sample_in) begin
        good_d = good_inc;
        bad_d  = '0;
        unique case (state_q)
          ST_IDLE, ST_ACQ: begin
            state_d = (good_inc >= LOCK_TH) ? ST_LOCKED : ST_ACQ;
          end
          ST_LOCKED: begin
            state_d = ST_LOCKED;
          end
          ST_FAULT: begin
            // Recovery restarts acquisition from a single good sample.
            good_d  = 4'd1;
            state_d = (LOCK_TH <= 4'd1) ? ST_LOCKED : ST_ACQ;
          end
        endcase
      end else begin
        good_d = '0;
        bad_d  = bad_inc;
        unique case (state_q)
          ST_IDLE, ST_ACQ: begin
            state_d = ST_IDLE;
          end
          ST_LOCKED: begin
            if (bad_inc >= LOSS_TH) begin
              state_d    = ST_FAULT;
              glitch_inc = 1'b1;
            end
          end
          ST_FAULT: begin
            state_d = ST_FAULT;
          end
        endcase
      end
    end

    // A clear always beats a coincident increment.
    if (clear_counts) begin
      glitch_d = '0;
    end else if (glitch_inc && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 16'd1;
    end

    // Registered copy of the lock decision, aligned with clk_state.
    clk_ok_d = (state_d == ST_LOCKED);
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign sample_strobe = strobe_q;
  assign rate_latched  = rate_latched_q;
  assign in_range      = in_range_q;
  assign clk_state     = state_q;
  assign clk_ok        = clk_ok_q;
  assign glitch_count  = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_rate_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_rate_monitor
//  Description : Self-checking bench for clk_rate_monitor. Directed lock /
//                loss / invalid / clear / reset scenarios followed by random
//                rate words, compared against a per-sample reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_rate_monitor;

  localparam int P    = 16;
  localparam int EXP  = 400000;
  localparam int TOL  = 400;
  localparam int LOCK = 3;
  localparam int LOSS = 2;

  logic        clk125 = 1'b0;
  logic        reset_n_in;
  logic [23:0] rate_value;
  logic        clear_counts;
  logic        sample_strobe;
  logic [23:0] rate_latched;
  logic        in_range;
  logic [1:0]  clk_state;
  logic        clk_ok;
  logic [15:0] glitch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (one update per sample)
  int          m_state;
  int          m_good;
  int          m_bad;
  int          m_glitch;
  int          m_inr;
  logic [23:0] m_lat;

  clk_rate_monitor #(
    .SAMPLE_PERIOD (P),
    .EXP_COUNT     (EXP),
    .TOL           (TOL),
    .LOCK_CNT      (LOCK),
    .LOSS_CNT      (LOSS)
  ) dut (
    .clk125        (clk125),
    .reset_n_in    (reset_n_in),
    .rate_value    (rate_value),
    .clear_counts  (clear_counts),
    .sample_strobe (sample_strobe),
    .rate_latched  (rate_latched),
    .in_range      (in_range),
    .clk_state     (clk_state),
    .clk_ok        (clk_ok),
    .glitch_count  (glitch_count)
  );

  always #5 clk125 = ~clk125;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_good   = 0;
    m_bad    = 0;
    m_glitch = 0;
    m_inr    = 0;
    m_lat    = '0;
  endtask

  // Debounce rules stated per sample, in plain integers.
  task automatic model_sample(input logic [23:0] v);
    int val;
    val   = int'(v);
    m_lat = v;
    if (v == 24'hFFFFFF) begin
      m_inr = 0; m_state = 0; m_good = 0; m_bad = 0;
    end else if (val >= EXP - TOL && val <= EXP + TOL) begin
      m_inr  = 1;
      m_good = (m_good + 1 > 15) ? 15 : m_good + 1;
      m_bad  = 0;
      if (m_state == 3) begin
        m_good  = 1;
        m_state = (LOCK <= 1) ? 2 : 1;
      end else if (m_state != 2) begin
        m_state = (m_good >= LOCK) ? 2 : 1;
      end
    end else begin
      m_inr  = 0;
      m_good = 0;
      m_bad  = (m_bad + 1 > 15) ? 15 : m_bad + 1;
      if (m_state == 1) m_state = 0;
      else if (m_state == 2 && m_bad >= LOSS) begin
        m_state  = 3;
        m_glitch = (m_glitch < 65535) ? m_glitch + 1 : 65535;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".rate_latched"}, rate_latched, m_lat);
    check_val({tag, ".in_range"},     in_range,     m_inr);
    check_val({tag, ".clk_state"},    clk_state,    m_state);
    check_val({tag, ".clk_ok"},       clk_ok,       (m_state == 2) ? 1 : 0);
    check_val({tag, ".glitch_count"}, glitch_count, m_glitch);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".strobe"},       sample_strobe, 0);
    check_val({tag, ".rate_latched"}, rate_latched,  0);
    check_val({tag, ".in_range"},     in_range,      0);
    check_val({tag, ".clk_state"},    clk_state,     0);
    check_val({tag, ".clk_ok"},       clk_ok,        0);
    check_val({tag, ".glitch_count"}, glitch_count,  0);
  endtask

  // Called at a negedge where a strobe was seen (or at reset release).
  // Drives the next sample value, optionally pulses clear_counts mid-period
  // or on the tick cycle, waits for the strobe and compares against the model.
  // Strobe is expected P falling edges later (spec cycle P+1 counting from 1).
  task automatic do_sample(input logic [23:0] v, input bit clr_tick, input bit clr_mid,
                           input string tag);
    int cyc;
    rate_value = v;
    cyc = -1;
    for (int n = 1; n <= 3 * P; n++) begin
      @(negedge clk125);
      clear_counts = 1'b0;
      if (sample_strobe) begin
        cyc = n;
        break;
      end
      if (clr_mid  && n == P / 2) clear_counts = 1'b1;
      if (clr_tick && n == P - 1) clear_counts = 1'b1;
    end
    clear_counts = 1'b0;
    check_val({tag, ".period"}, cyc, P);
    if (clr_mid) m_glitch = 0;
    model_sample(v);
    if (clr_tick) m_glitch = 0;
    check_outputs(tag);
  endtask

  function automatic logic [23:0] pick_value();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return 24'(EXP - TOL + $urandom_range(0, 2 * TOL));
      4:          return ($urandom_range(0, 1) == 0) ? 24'(EXP - TOL) : 24'(EXP + TOL);
      5:          return ($urandom_range(0, 1) == 0) ? 24'(EXP - TOL - 1) : 24'(EXP + TOL + 1);
      6:          return 24'd0;
      7:          return ($urandom_range(0, 2) == 0) ? 24'hFFFFFF : 24'd500000;
      8:          return 24'($urandom);
      default:    return 24'(EXP);
    endcase
  endfunction

  initial begin
    reset_n_in   = 1'b0;
    rate_value   = 24'(EXP);
    clear_counts = 1'b0;
    model_reset();
    repeat (3) @(negedge clk125);
    check_all_zero("reset");
    reset_n_in = 1'b1;

    // Acquire: states 1,1,2
    for (int i = 0; i < 3; i++) do_sample(24'(EXP), 1'b0, 1'b0, "acq");

    // Window edges while locked
    do_sample(24'd399600, 1'b0, 1'b0, "lo_edge");
    do_sample(24'd400400, 1'b0, 1'b0, "hi_edge");
    do_sample(24'd399599, 1'b0, 1'b0, "below_lo");
    do_sample(24'(EXP),   1'b0, 1'b0, "relock0");
    do_sample(24'd400401, 1'b0, 1'b0, "above_hi");
    do_sample(24'(EXP),   1'b0, 1'b0, "relock1");

    // Stopped clock: loss of lock then recovery
    do_sample(24'd0, 1'b0, 1'b0, "stop0");
    do_sample(24'd0, 1'b0, 1'b0, "stop1");
    for (int i = 0; i < 3; i++) do_sample(24'(EXP), 1'b0, 1'b0, "recover");

    // Single glitch sample does not drop lock
    do_sample(24'd500000, 1'b0, 1'b0, "single_bad");
    do_sample(24'(EXP),   1'b0, 1'b0, "single_ok");

    // Upstream invalid
    do_sample(24'hFFFFFF, 1'b0, 1'b0, "invalid");
    for (int i = 0; i < 3; i++) do_sample(24'(EXP), 1'b0, 1'b0, "acq2");

    // Clear coincident with LOCKED->FAULT increment
    do_sample(24'd0, 1'b0, 1'b0, "clr_pre");
    do_sample(24'd0, 1'b1, 1'b0, "clr_tick");
    for (int i = 0; i < 3; i++) do_sample(24'(EXP), 1'b0, 1'b0, "acq3");

    // Asynchronous reset mid-period
    rate_value = 24'(EXP);
    repeat (5) @(negedge clk125);
    #2 reset_n_in = 1'b0;
    #1 check_all_zero("mid_reset");
    model_reset();
    @(negedge clk125);
    reset_n_in = 1'b1;
    do_sample(24'(EXP), 1'b0, 1'b0, "post_reset");

    // Random rate words with occasional clears
    for (int i = 0; i < 60; i++) begin
      do_sample(pick_value(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
